mem_access_ctrl: RTL and testbench

Sequences data-memory transactions for the MEM stage of the pipelined CPU.
- Decodes load/store requests held in the EX/MEM pipeline register and drives a req/ack data-memory port.
- Asserts Stall to freeze the PC, IF/ID, ID/EX and EX/MEM registers until the access completes.
- Performs byte/half/word lane steering and load extension, and flags misaligned accesses and memory timeouts.

---
 rtl/mem_access_ctrl_if.sv | 20 ++
 rtl/mem_access_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - data-memory req/ack port between MEM stage and memory
interface mem_access_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage load/store sequencer with stall, lane steering and fault flags
module mem_access_ctrl #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 8
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     M_MemWrite,
  input  logic                     M_MemtoReg,
  input  logic [31:0]              M_ALUanswer,
  input  logic [31:0]              M_Qb,
  input  logic [2:0]               M_load_option,
  input  logic [1:0]               M_save_option,
  mem_access_ctrl_if.master        mem,
  output logic                     Stall,
  output logic [31:0]              LoadData,
  output logic                     LoadValid,
  output logic                     AddrErr,
  output logic                     BusErr,
  output logic [31:0]              ErrAddr
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  state_t            state;
  logic [31:0]       addr_q;
  logic              we_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic [2:0]        ld_type_q;
  logic [1:0]        off_q;
  logic [CNT_W-1:0]  wait_cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic              bus_err_q;

  logic [1:0]        off;
  logic              is_st;
  logic              is_ld;
  logic              aligned;
  logic              want;
  logic              accept;
  logic              busy;
  logic [3:0]        st_be;
  logic [31:0]       st_wdata;
  logic [31:0]       load_ext;
  logic [15:0]       half_sel;
  logic [7:0]        byte_sel;

  assign off     = M_ALUanswer[1:0];
  assign busy    = (state == S_REQ) || (state == S_WAIT);
  assign cnt_inc = wait_cnt + CNT_W'(1);

  // Decode the EX/MEM request: access kind, alignment and store lane steering
  always_comb begin
    is_st    = M_MemWrite && (M_save_option != 2'd0);
    is_ld    = M_MemtoReg && (M_load_option >= 3'd1) && (M_load_option <= 3'd5) && !is_st;
    aligned  = 1'b1;
    st_be    = 4'b1111;
    st_wdata = 32'd0;
    if (is_st) begin
      case (M_save_option)
        2'd1: begin
          aligned  = (off == 2'd0);
          st_be    = 4'b1111;
          st_wdata = M_Qb;
        end
        2'd2: begin
          aligned  = !off[0];
          st_be    = off[1] ? 4'b1100 : 4'b0011;
          st_wdata = {M_Qb[15:0], M_Qb[15:0]};
        end
        default: begin
          aligned  = 1'b1;
          st_be    = 4'b0001 << off;
          st_wdata = {4{M_Qb[7:0]}};
        end
      endcase
    end else begin
      case (M_load_option)
        3'd1:       aligned = (off == 2'd0);
        3'd2, 3'd3: aligned = !off[0];
        default:    aligned = 1'b1;
      endcase
    end
    // The cycle that reports a bus error lets the faulted instruction leave
    // without being re-issued; reset also masks the combinational outputs.
    want    = (is_st || is_ld) && !bus_err_q && Reset;
    accept  = (state == S_IDLE) && want && aligned;
    AddrErr = (state == S_IDLE) && want && !aligned;
  end

  assign Stall = accept || busy;

  assign mem.mem_req   = busy;
  assign mem.mem_we    = busy && we_q;
  assign mem.mem_addr  = busy ? {addr_q[31:2], 2'b00} : 32'd0;
  assign mem.mem_wdata = busy ? wdata_q : 32'd0;
  assign mem.mem_be    = busy ? be_q : 4'b0000;

  // Extract and extend the addressed lane from the returning read word
  always_comb begin
    half_sel = off_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
    byte_sel = mem.mem_rdata[{off_q, 3'b000} +: 8];
    case (ld_type_q)
      3'd1:    load_ext = mem.mem_rdata;
      3'd2:    load_ext = {{16{half_sel[15]}}, half_sel};
      3'd3:    load_ext = {16'd0, half_sel};
      3'd4:    load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'd5:    load_ext = {24'd0, byte_sel};
      default: load_ext = 32'd0;
    endcase
  end

  // Transaction FSM with latched request and registered result/fault outputs
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= S_IDLE;
      addr_q    <= 32'd0;
      we_q      <= 1'b0;
      be_q      <= 4'b0000;
      wdata_q   <= 32'd0;
      ld_type_q <= 3'd0;
      off_q     <= 2'd0;
      wait_cnt  <= '0;
      bus_err_q <= 1'b0;
      LoadData  <= 32'd0;
      LoadValid <= 1'b0;
      ErrAddr   <= 32'd0;
    end else begin
      LoadValid <= 1'b0;
      bus_err_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            addr_q    <= M_ALUanswer;
            we_q      <= is_st;
            be_q      <= st_be;
            wdata_q   <= st_wdata;
            ld_type_q <= is_ld ? M_load_option : 3'd0;
            off_q     <= off;
            wait_cnt  <= '0;
            state     <= S_REQ;
          end else if (AddrErr) begin
            ErrAddr <= M_ALUanswer;
          end
        end
        S_REQ: begin
          if (mem.mem_ack) begin
            if (ld_type_q != 3'd0) begin
              LoadData  <= load_ext;
              LoadValid <= 1'b1;
            end
            state <= S_DONE;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem.mem_ack) begin
            if (ld_type_q != 3'd0) begin
              LoadData  <= load_ext;
              LoadValid <= 1'b1;
            end
            state <= S_DONE;
          end else if (cnt_inc == MAX_CNT) begin
            bus_err_q <= 1'b1;
            ErrAddr   <= addr_q;
            state     <= S_IDLE;
          end else begin
            wait_cnt <= cnt_inc;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign BusErr = bus_err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - self-checking bench for mem_access_ctrl
module tb_mem_access_ctrl;
  localparam int MAX_WAIT = 15;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        M_MemWrite;
  logic        M_MemtoReg;
  logic [31:0] M_ALUanswer;
  logic [31:0] M_Qb;
  logic [2:0]  M_load_option;
  logic [1:0]  M_save_option;
  logic        Stall;
  logic [31:0] LoadData;
  logic        LoadValid;
  logic        AddrErr;
  logic        BusErr;
  logic [31:0] ErrAddr;

  int checks   = 0;
  int failures = 0;
  logic [31:0] last_load = 32'd0;

  mem_access_ctrl_if bus ();

  mem_access_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(8)) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .M_MemWrite    (M_MemWrite),
    .M_MemtoReg    (M_MemtoReg),
    .M_ALUanswer   (M_ALUanswer),
    .M_Qb          (M_Qb),
    .M_load_option (M_load_option),
    .M_save_option (M_save_option),
    .mem           (bus.master),
    .Stall         (Stall),
    .LoadData      (LoadData),
    .LoadValid     (LoadValid),
    .AddrErr       (AddrErr),
    .BusErr        (BusErr),
    .ErrAddr       (ErrAddr)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_inputs();
    M_MemWrite    = 1'b0;
    M_MemtoReg    = 1'b0;
    M_load_option = 3'd0;
    M_save_option = 2'd0;
  endtask

  function automatic int access_size(input bit st, input logic [2:0] lo, input logic [1:0] so);
    if (st) return (so == 2'd1) ? 4 : (so == 2'd2) ? 2 : 1;
    return (lo == 3'd1) ? 4 : (lo <= 3'd3) ? 2 : 1;
  endfunction

  function automatic logic [3:0] model_be(input bit st, input int sz, input logic [31:0] addr);
    int m;
    if (!st) return 4'hF;
    m = ((1 << sz) - 1) << (addr % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input bit st, input int sz, input logic [31:0] qb);
    if (!st) return 32'd0;
    if (sz == 4) return qb;
    if (sz == 2) return (qb & 32'hFFFF) * 32'h0001_0001;
    return (qb & 32'hFF) * 32'h0101_0101;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] lo, input int sz, input logic [31:0] addr,
                                             input logic [31:0] rdata);
    logic [31:0] v;
    logic [31:0] mask;
    v    = rdata >> (8 * (addr % 4));
    mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
    v    = v & mask;
    if ((lo == 3'd2 || lo == 3'd4) && ((v >> (8 * sz - 1)) & 32'd1) == 32'd1) v = v | ~mask;
    return v;
  endfunction

  // One pipeline access: ack_wait = number of WAIT cycles before ack (0 = ack in REQ, <0 = never)
  task automatic access(input bit mw, input bit mr, input logic [2:0] lo, input logic [1:0] so,
                        input logic [31:0] addr, input logic [31:0] qb, input logic [31:0] rdata,
                        input int ack_wait);
    bit st, ld;
    int sz, stalls;
    logic [31:0] exp_ld;
    M_MemWrite = mw; M_MemtoReg = mr; M_load_option = lo; M_save_option = so;
    M_ALUanswer = addr; M_Qb = qb;
    #1;
    st = mw && (so != 2'd0);
    ld = !st && mr && (lo >= 3'd1) && (lo <= 3'd5);
    if (!st && !ld) begin
      chk("noacc_stall", Stall, 0);
      chk("noacc_addrerr", AddrErr, 0);
      step();
      chk("noacc_req", bus.mem_req, 0);
      clear_inputs();
      return;
    end
    sz = access_size(st, lo, so);
    if ((addr % sz) != 0) begin
      chk("mis_addrerr", AddrErr, 1);
      chk("mis_stall", Stall, 0);
      chk("mis_req", bus.mem_req, 0);
      step();
      clear_inputs();
      #1;
      chk("mis_erraddr", ErrAddr, addr);
      chk("mis_addrerr_clr", AddrErr, 0);
      chk("mis_req_after", bus.mem_req, 0);
      return;
    end
    chk("idle_stall", Stall, 1);
    chk("idle_req", bus.mem_req, 0);
    stalls = 1;
    step();
    for (int w = 0; w <= MAX_WAIT; w++) begin
      chk("req", bus.mem_req, 1);
      chk("we", bus.mem_we, st);
      chk("addr", bus.mem_addr, addr & 32'hFFFF_FFFC);
      chk("be", bus.mem_be, model_be(st, sz, addr));
      chk("wdata", bus.mem_wdata, model_wdata(st, sz, qb));
      if (Stall) stalls++;
      if (w == ack_wait) begin
        bus.mem_ack = 1'b1;
        bus.mem_rdata = rdata;
        step();
        bus.mem_ack = 1'b0;
        bus.mem_rdata = $urandom;
        break;
      end
      if (w == MAX_WAIT) begin
        step();
        chk("to_buserr", BusErr, 1);
        chk("to_erraddr", ErrAddr, addr);
        chk("to_stall", Stall, 0);
        chk("to_req", bus.mem_req, 0);
        clear_inputs();
        step();
        chk("to_buserr_clr", BusErr, 0);
        chk("to_stall_after", Stall, 0);
        return;
      end
      step();
    end
    chk("done_stall", Stall, 0);
    chk("done_req", bus.mem_req, 0);
    chk("done_be", bus.mem_be, 0);
    chk("done_buserr", BusErr, 0);
    chk("done_loadvalid", LoadValid, ld);
    chk("stall_cycles", stalls, 2 + ack_wait);
    if (ld) last_load = model_load(lo, sz, addr, rdata);
    chk("loaddata", LoadData, last_load);
    clear_inputs();
    step();
    chk("post_loadvalid", LoadValid, 0);
    chk("post_loaddata", LoadData, last_load);
  endtask

  initial begin
    Reset = 1'b0;
    clear_inputs();
    M_ALUanswer = 32'd0;
    M_Qb = 32'd0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = 32'd0;
    #3;
    chk("rst_req", bus.mem_req, 0);
    chk("rst_stall", Stall, 0);
    chk("rst_loaddata", LoadData, 0);
    chk("rst_errs", {BusErr, AddrErr, LoadValid}, 0);
    chk("rst_erraddr", ErrAddr, 0);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    step();

    access(1'b0, 1'b1, 3'd1, 2'd0, 32'h0000_0010, 32'd0, 32'hDEAD_BEEF, 0);
    chk("lw_const", LoadData, 32'hDEAD_BEEF);
    access(1'b0, 1'b1, 3'd4, 2'd0, 32'h0000_0013, 32'd0, 32'h80FF_0102, 3);
    chk("lb_const", LoadData, 32'hFFFF_FF80);
    access(1'b0, 1'b1, 3'd5, 2'd0, 32'h0000_0013, 32'd0, 32'h80FF_0102, 3);
    chk("lbu_const", LoadData, 32'h0000_0080);
    access(1'b1, 1'b0, 3'd0, 2'd2, 32'h0000_0022, 32'h1234_ABCD, 32'd0, 0);
    access(1'b1, 1'b0, 3'd0, 2'd3, 32'h0000_0021, 32'h0000_0055, 32'd0, 1);
    access(1'b0, 1'b1, 3'd1, 2'd0, 32'h0000_0006, 32'd0, 32'd0, 0);
    chk("mis_const", ErrAddr, 32'h0000_0006);
    access(1'b1, 1'b0, 3'd0, 2'd1, 32'h0000_0040, 32'hCAFE_F00D, 32'd0, -1);
    chk("to_const", ErrAddr, 32'h0000_0040);
    access(1'b1, 1'b0, 3'd0, 2'd1, 32'h0000_0044, 32'h0BAD_CAFE, 32'd0, MAX_WAIT);
    access(1'b1, 1'b1, 3'd2, 2'd1, 32'h0000_0050, 32'h1111_2222, 32'h7777_8888, 0);
    access(1'b0, 1'b1, 3'd6, 2'd0, 32'h0000_0060, 32'd0, 32'd0, 0);
    access(1'b0, 1'b1, 3'd2, 2'd0, 32'h0000_0072, 32'd0, 32'h8001_7FFF, 2);
    access(1'b0, 1'b1, 3'd3, 2'd0, 32'h0000_0072, 32'd0, 32'h8001_7FFF, 0);
    access(1'b1, 1'b0, 3'd0, 2'd2, 32'h0000_0023, 32'hAAAA_BBBB, 32'd0, 0);

    for (int i = 0; i < 40; i++) begin
      access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             2'($urandom_range(0, 3)), $urandom & 32'h0000_0FFF, $urandom, $urandom,
             int'($urandom_range(0, 4)));
    end

    // Reset during WAIT, then a stale ack after release
    M_MemtoReg = 1'b1; M_load_option = 3'd1; M_ALUanswer = 32'h0000_0080;
    #1;
    chk("rw_idle_stall", Stall, 1);
    step();
    step();
    step();
    chk("rw_wait_req", bus.mem_req, 1);
    #2;
    Reset = 1'b0;
    #1;
    chk("rw_req", bus.mem_req, 0);
    chk("rw_stall", Stall, 0);
    chk("rw_erraddr", ErrAddr, 0);
    chk("rw_loaddata", LoadData, 0);
    clear_inputs();
    @(negedge Clk);
    Reset = 1'b1;
    step();
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'h1234_5678;
    step();
    bus.mem_ack = 1'b0;
    chk("late_loadvalid", LoadValid, 0);
    chk("late_loaddata", LoadData, 0);
    chk("late_req", bus.mem_req, 0);
    step();
    chk("late_loadvalid2", LoadValid, 0);
    chk("late_stall", Stall, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
